// File: rtl/fat32_dir_entry_writer.sv
// Builds one FAT32 directory record (LFN + 8.3 entry) in the root-dir sector buffer,
// patches the serially computed SFN checksum into the LFN, then requests the sector write.
module fat32_dir_entry_writer #(
  parameter  int unsigned SECTOR_BYTES = 512,
  localparam int unsigned ENTRY_BYTES  = 32,
  localparam int unsigned AW           = $clog2(SECTOR_BYTES)
) (
  input  logic          updateClock,
  input  logic          rstn,
  input  logic          start,
  input  logic [3:0]    entrySlot,
  input  logic [255:0]  sfnEntry,
  input  logic [255:0]  lfnEntry,
  input  logic [15:0]   reservedSectors,
  input  logic [31:0]   fatLength,
  input  logic [7:0]    numberOfFat,
  input  logic          sdWriteAck,
  input  logic          sdWriteDone,
  input  logic          sdWriteErr,
  output logic          busy,
  output logic          bufWe,
  output logic [AW-1:0] bufAddr,
  output logic [7:0]    bufData,
  output logic          sectorWriteReq,
  output logic [31:0]   sectorAddr,
  output logic [7:0]    checksum,
  output logic          done,
  output logic          error
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] NAME_LAST  = CW'(10);
  localparam logic [CW-1:0] ENTRY_LAST = CW'(ENTRY_BYTES - 1);
  localparam logic [CW-1:0] CSUM_BYTE  = CW'(13);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CALC     = 3'd1;
  localparam logic [2:0] FILL_LFN = 3'd2;
  localparam logic [2:0] FILL_SFN = 3'd3;
  localparam logic [2:0] REQ      = 3'd4;
  localparam logic [2:0] WAIT     = 3'd5;

  logic [2:0]    state, stateN;
  logic [CW-1:0] cnt, cntN;
  logic [3:0]    slotQ, slotN, sfnSlot;
  logic [255:0]  sfnQ, sfnN, lfnQ, lfnN;
  logic [7:0]    sfnByte, lfnByte;
  logic [7:0]    checksumN, bufDataN;
  logic [31:0]   sectorAddrN;
  logic [AW-1:0] bufAddrN;
  logic          bufWeN, reqN, doneN, errorN, busyN;

  assign sfnSlot = slotQ + 4'd1;
  assign sfnByte = sfnQ[{cnt, 3'b000} +: 8];
  assign lfnByte = lfnQ[{cnt, 3'b000} +: 8];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    stateN      = state;
    cntN        = cnt;
    slotN       = slotQ;
    sfnN        = sfnQ;
    lfnN        = lfnQ;
    checksumN   = checksum;
    sectorAddrN = sectorAddr;
    bufAddrN    = bufAddr;
    bufDataN    = bufData;
    bufWeN      = 1'b0;
    reqN        = 1'b0;
    doneN       = 1'b0;
    errorN      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (entrySlot == 4'd15) begin
            doneN  = 1'b1;
            errorN = 1'b1;
          end else begin
            slotN       = entrySlot;
            sfnN        = sfnEntry;
            lfnN        = lfnEntry;
            checksumN   = 8'd0;
            sectorAddrN = 32'(32'(reservedSectors) + fatLength * 32'(numberOfFat));
            cntN        = '0;
            stateN      = CALC;
          end
        end
      end
      CALC: begin
        checksumN = 8'({checksum[0], checksum[7:1]} + sfnByte);
        cntN      = cnt + CW'(1);
        if (cnt == NAME_LAST) begin
          cntN   = '0;
          stateN = FILL_LFN;
        end
      end
      FILL_LFN: begin
        bufWeN   = 1'b1;
        bufAddrN = AW'({slotQ, cnt});
        bufDataN = (cnt == CSUM_BYTE) ? checksum : lfnByte;
        cntN     = cnt + CW'(1);
        if (cnt == ENTRY_LAST) stateN = FILL_SFN;
      end
      FILL_SFN: begin
        bufWeN   = 1'b1;
        bufAddrN = AW'({sfnSlot, cnt});
        bufDataN = sfnByte;
        cntN     = cnt + CW'(1);
        if (cnt == ENTRY_LAST) stateN = REQ;
      end
      REQ: begin
        reqN = 1'b1;
        // Ack only counts once the request is actually visible to the SD writer.
        if (sectorWriteReq && sdWriteAck) begin
          reqN = 1'b0;
          if (sdWriteDone) begin
            doneN  = 1'b1;
            errorN = sdWriteErr;
            stateN = IDLE;
          end else begin
            stateN = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdWriteDone) begin
          doneN  = 1'b1;
          errorN = sdWriteErr;
          stateN = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
    busyN = (stateN != IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge updateClock or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      slotQ          <= '0;
      sfnQ           <= '0;
      lfnQ           <= '0;
      checksum       <= '0;
      sectorAddr     <= '0;
      bufWe          <= 1'b0;
      bufAddr        <= '0;
      bufData        <= '0;
      sectorWriteReq <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= stateN;
      cnt            <= cntN;
      slotQ          <= slotN;
      sfnQ           <= sfnN;
      lfnQ           <= lfnN;
      checksum       <= checksumN;
      sectorAddr     <= sectorAddrN;
      bufWe          <= bufWeN;
      bufAddr        <= bufAddrN;
      bufData        <= bufDataN;
      sectorWriteReq <= reqN;
      done           <= doneN;
      error          <= errorN;
      busy           <= busyN;
    end
  end

endmodule

// File: tb/tb_fat32_dir_entry_writer.sv
// Scoreboard bench for fat32_dir_entry_writer: expected buffer writes are queued at start
// and popped as bufWe strobes appear; handshake timing and status outputs checked per scenario.
module tb_fat32_dir_entry_writer;

  logic         updateClock = 1'b0;
  logic         rstn;
  logic         start;
  logic [3:0]   entrySlot;
  logic [255:0] sfnEntry, lfnEntry;
  logic [15:0]  reservedSectors;
  logic [31:0]  fatLength;
  logic [7:0]   numberOfFat;
  logic         sdWriteAck, sdWriteDone, sdWriteErr;
  logic         busy, bufWe, sectorWriteReq, done, error;
  logic [8:0]   bufAddr;
  logic [7:0]   bufData, checksum;
  logic [31:0]  sectorAddr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t sb[$];

  logic [7:0]  lastCs = 8'd0;
  logic [31:0] lastSa = 32'd0;

  fat32_dir_entry_writer dut (
    .updateClock(updateClock), .rstn(rstn), .start(start), .entrySlot(entrySlot),
    .sfnEntry(sfnEntry), .lfnEntry(lfnEntry), .reservedSectors(reservedSectors),
    .fatLength(fatLength), .numberOfFat(numberOfFat), .sdWriteAck(sdWriteAck),
    .sdWriteDone(sdWriteDone), .sdWriteErr(sdWriteErr), .busy(busy), .bufWe(bufWe),
    .bufAddr(bufAddr), .bufData(bufData), .sectorWriteReq(sectorWriteReq),
    .sectorAddr(sectorAddr), .checksum(checksum), .done(done), .error(error)
  );

  always #5 updateClock = ~updateClock;

  function automatic logic [7:0] model_cs(input logic [255:0] s);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < 11; i++) c = 8'({c[0], c[7:1]} + s[8*i +: 8]);
    return c;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_op(input string nm, input logic [3:0] slot, input logic [255:0] sfn,
                       input logic [255:0] lfn, input logic [15:0] rs, input logic [31:0] fl,
                       input logic [7:0] nf, input int ackDly, input int doneDly,
                       input logic errIn, input bit poke);
    logic [7:0]  cs, expCs;
    logic [31:0] sa, expSa;
    logic        expErr;
    int firstWe = -1, lastWe = -1, weCnt = 0, firstReq = -1, reqCnt = 0;
    int doneCnt = 0, doneAt = -1, endAt = -1;
    bool_t_dummy: begin end
    cs     = model_cs(sfn);
    sa     = 32'(32'(rs) + fl * 32'(nf));
    expErr = (slot == 4'd15) ? 1'b1 : errIn;
    expCs  = (slot == 4'd15) ? lastCs : cs;
    expSa  = (slot == 4'd15) ? lastSa : sa;
    @(negedge updateClock);
    entrySlot = slot; sfnEntry = sfn; lfnEntry = lfn;
    reservedSectors = rs; fatLength = fl; numberOfFat = nf;
    start = 1'b1;
    @(posedge updateClock);
    #1 start = 1'b0;
    if (slot != 4'd15) begin
      for (int i = 0; i < 32; i++)
        sb.push_back('{addr: 9'(slot * 32 + i), data: (i == 13) ? cs : lfn[8*i +: 8]});
      for (int i = 0; i < 32; i++)
        sb.push_back('{addr: 9'((slot + 1) * 32 + i), data: sfn[8*i +: 8]});
    end
    for (int k = 0; k < 400 && (endAt < 0 || k < endAt); k++) begin
      @(negedge updateClock);
      if (k == 0) begin
        tests++;
        if (busy !== (slot != 4'd15) || (slot != 4'd15 && sectorAddr !== sa)) begin
          fails++;
          $display("FAIL %s accept: busy=%0b sectorAddr=%h, expected busy=%0b sectorAddr=%h",
                   nm, busy, sectorAddr, slot != 4'd15, sa);
        end
      end
      if (bufWe) begin
        weCnt++;
        if (firstWe < 0) firstWe = k;
        lastWe = k;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s write: unexpected addr=%0d data=%02h at cycle %0d", nm, bufAddr, bufData, k);
        end else begin
          wr_t w;
          w = sb.pop_front();
          if (bufAddr !== w.addr || bufData !== w.data) begin
            fails++;
            $display("FAIL %s write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                     nm, bufAddr, bufData, w.addr, w.data);
          end
        end
      end
      if (sectorWriteReq) begin
        reqCnt++;
        if (firstReq < 0) firstReq = k;
      end
      if (done) begin
        doneCnt++;
        doneAt = k;
        endAt  = k + 3;
        tests++;
        if (error !== expErr || busy !== 1'b0 || sectorAddr !== expSa) begin
          fails++;
          $display("FAIL %s done: error=%0b busy=%0b sectorAddr=%h, expected error=%0b busy=0 sectorAddr=%h",
                   nm, error, busy, sectorAddr, expErr, expSa);
        end
      end
      if (poke && k == 20) begin
        start = 1'b1;
        entrySlot = 4'd3;
        lfnEntry = ~lfn;
        sfnEntry = ~sfn;
      end else begin
        start = 1'b0;
      end
      sdWriteAck  = (firstReq >= 0 && k == firstReq + ackDly);
      sdWriteDone = (firstReq >= 0 && k == firstReq + ackDly + doneDly);
      sdWriteErr  = errIn && sdWriteDone;
    end
    sdWriteAck = 1'b0; sdWriteDone = 1'b0; sdWriteErr = 1'b0; start = 1'b0;

    tests++;
    if (slot == 4'd15) begin
      if (weCnt != 0 || reqCnt != 0 || doneCnt != 1 || doneAt != 0) begin
        fails++;
        $display("FAIL %s slot15: writes=%0d reqs=%0d dones=%0d doneAt=%0d, expected 0/0/1/0",
                 nm, weCnt, reqCnt, doneCnt, doneAt);
      end
    end else begin
      if (weCnt != 64 || firstWe != 12 || lastWe != 75 || firstReq != 76 || reqCnt != ackDly + 1 ||
          doneCnt != 1 || doneAt != 77 + ackDly + doneDly) begin
        fails++;
        $display("FAIL %s timing: writes=%0d first=%0d last=%0d req=%0d reqLen=%0d dones=%0d doneAt=%0d, expected 64/12/75/76/%0d/1/%0d",
                 nm, weCnt, firstWe, lastWe, firstReq, reqCnt, doneCnt, doneAt, ackDly + 1, 77 + ackDly + doneDly);
      end
    end
    tests++;
    if (sb.size() != 0 || checksum !== expCs || sectorAddr !== expSa || busy !== 1'b0 || sectorWriteReq !== 1'b0) begin
      fails++;
      $display("FAIL %s end: pending=%0d checksum=%02h sectorAddr=%h busy=%0b req=%0b, expected 0/%02h/%h/0/0",
               nm, sb.size(), checksum, sectorAddr, busy, sectorWriteReq, expCs, expSa);
    end
    sb.delete();
    lastCs = expCs;
    lastSa = expSa;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; entrySlot = '0; sfnEntry = '0; lfnEntry = '0;
    reservedSectors = '0; fatLength = '0; numberOfFat = '0;
    sdWriteAck = 1'b0; sdWriteDone = 1'b0; sdWriteErr = 1'b0;
    repeat (3) @(negedge updateClock);
    tests++;
    if ({busy, bufWe, bufAddr, bufData, sectorWriteReq, sectorAddr, checksum, done, error} !== '0) begin
      fails++;
      $display("FAIL reset: outputs busy=%0b we=%0b addr=%0d data=%02h req=%0b sa=%h cs=%02h done=%0b err=%0b, expected all 0",
               busy, bufWe, bufAddr, bufData, sectorWriteReq, sectorAddr, checksum, done, error);
    end
    rstn = 1'b1;
    lastCs = 8'd0; lastSa = 32'd0;
  endtask

  task automatic test_root_addr();
    do_op("root_addr", 4'd2, rnd256(), rnd256(), 16'd32, 32'h3C1, 8'd2, 0, 3, 1'b0, 1'b0);
    tests++;
    if (sectorAddr !== 32'h7A2) begin
      fails++;
      $display("FAIL root_addr: sectorAddr=%h, expected 000007a2", sectorAddr);
    end
  endtask

  task automatic test_checksum();
    logic [255:0] s;
    s = rnd256();
    for (int i = 0; i < 11; i++) s[8*i +: 8] = 8'h01;
    do_op("checksum", 4'd6, s, rnd256(), 16'd1, 32'h1234, 8'd2, 1, 2, 1'b0, 1'b0);
    tests++;
    if (checksum !== 8'h81) begin
      fails++;
      $display("FAIL checksum: got %02h, expected 81", checksum);
    end
    do_op("checksum_rand", 4'd9, rnd256(), rnd256(), 16'hFFFF, 32'hFFFF_0000, 8'd3, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_slot_mapping();
    do_op("slot14", 4'd14, rnd256(), rnd256(), 16'd8, 32'd100, 8'd1, 2, 4, 1'b0, 1'b0);
    do_op("slot15", 4'd15, rnd256(), rnd256(), 16'd9, 32'd55, 8'd2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    do_op("handshake", 4'd4, rnd256(), rnd256(), 16'd32, 32'd7000, 8'd2, 5, 20, 1'b0, 1'b1);
  endtask

  task automatic test_sd_error();
    do_op("sd_error", 4'd1, rnd256(), rnd256(), 16'd38, 32'd1000, 8'd2, 3, 6, 1'b1, 1'b0);
    do_op("sd_error_same_cycle", 4'd11, rnd256(), rnd256(), 16'd4, 32'd9, 8'd5, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_a", 4'd0, rnd256(), rnd256(), 16'd16, 32'd200, 8'd2, 0, 1, 1'b0, 1'b0);
    do_op("b2b_b", 4'd7, rnd256(), rnd256(), 16'd20, 32'd300, 8'd2, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int weAfter = 0;
    @(negedge updateClock);
    entrySlot = 4'd5; sfnEntry = rnd256(); lfnEntry = rnd256();
    reservedSectors = 16'd32; fatLength = 32'd500; numberOfFat = 8'd2;
    start = 1'b1;
    @(posedge updateClock);
    #1 start = 1'b0;
    repeat (51) @(negedge updateClock);
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({busy, bufWe, bufAddr, bufData, sectorWriteReq, sectorAddr, checksum, done, error} !== '0) begin
      fails++;
      $display("FAIL reset_mid: outputs busy=%0b we=%0b addr=%0d data=%02h req=%0b sa=%h cs=%02h, expected all 0",
               busy, bufWe, bufAddr, bufData, sectorWriteReq, sectorAddr, checksum);
    end
    repeat (3) begin
      @(negedge updateClock);
      if (bufWe || sectorWriteReq || done) weAfter++;
    end
    tests++;
    if (weAfter != 0) begin
      fails++;
      $display("FAIL reset_mid hold: %0d active cycles during reset, expected 0", weAfter);
    end
    rstn = 1'b1;
    lastCs = 8'd0; lastSa = 32'd0;
    do_op("after_reset", 4'd5, rnd256(), rnd256(), 16'd32, 32'd500, 8'd2, 1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_root_addr();
    test_checksum();
    test_slot_mapping();
    test_handshake();
    test_sd_error();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
